sequence_detector_param: RTL and testbench

- Parametrised successor to the fixed-pattern Moore sequence detector.
- Detects a runtime-programmable serial bit pattern of 1..MAX_LEN bits, with selectable overlapping or non-overlapping detection.
- Adds an input-valid qualifier and a saturating match counter.
- Sits on the serial input path; detector_out is a registered single-cycle pulse per match.

---
 rtl/sequence_detector_param.sv | 146 ++++++++++++++
 tb/tb_sequence_detector_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_detector_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sequence_detector_param
//
// Serial pattern detector with a runtime-programmable pattern of 1..MAX_LEN
// bits. It supports overlapping and non-overlapping detection, an input-valid
// qualifier and a saturating match counter. A match raises detector_out for
// exactly one cycle, on the same edge that samples the completing bit.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset; clears all state and config
//   sequence_in  serial data bit
//   in_valid     sequence_in is sampled only when this is 1
//   cfg_load     latches pattern / pattern_len / overlap_en and clears history
//   pattern      pattern bits; pattern[len-1] is received first, pattern[0] last
//   pattern_len  pattern length in bits (0 disables the detector)
//   overlap_en   1 = overlapping detection, 0 = non-overlapping
//   count_clear  synchronous clear of match_count; wins over a simultaneous match
//   detector_out registered one-cycle match pulse
//   match_count  saturating count of matches
//   cfg_err      the last loaded pattern_len was 0 or larger than MAX_LEN
// -----------------------------------------------------------------------------
module sequence_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pattern_len,
    input  logic               overlap_en,
    input  logic               count_clear,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    // Candidate history/fill values for a valid sample, plus the match test on
    // those shifted-in values so the pulse lands on the completing edge.
    // Only the low len bits take part in the comparison.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], sequence_in};
        fill_inc   = (fill_q < MAX_LEN_L) ? fill_q + 1'b1 : fill_q;
        len_mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        match = (len_q != '0) && (fill_inc >= len_q) &&
                (((hist_shift ^ pattern_q) & len_mask) == '0);
    end

    // Next-state logic. cfg_load takes precedence over a valid sample, and
    // count_clear overrides any increment made in the same cycle.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        det_d     = 1'b0;
        count_d   = count_q;
        cfg_err_d = cfg_err_q;

        if (cfg_load) begin
            pattern_d = pattern;
            overlap_d = overlap_en;
            hist_d    = '0;
            fill_d    = '0;
            if (pattern_len == '0) begin
                len_d     = '0;
                cfg_err_d = 1'b1;
            end else if (pattern_len > MAX_LEN_L) begin
                len_d     = MAX_LEN_L;
                cfg_err_d = 1'b1;
            end else begin
                len_d     = pattern_len;
                cfg_err_d = 1'b0;
            end
        end else if (in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (match) begin
                det_d = 1'b1;
                if (count_q != '1) begin
                    count_d = count_q + 1'b1;
                end
                // Non-overlapping mode needs len fresh bits for the next match.
                if (!overlap_q) begin
                    fill_d = '0;
                end
            end
        end

        if (count_clear) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            det_q     <= 1'b0;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            det_q     <= det_d;
            count_q   <= count_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign detector_out = det_q;
    assign match_count  = count_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_sequence_detector_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sequence_detector_param
//
// Directed bench for sequence_detector_param. Two instances share all inputs:
// u_dut uses a 16-bit counter, u_dut_sat a 2-bit counter to reach saturation.
// -----------------------------------------------------------------------------
module tb_sequence_detector_param;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        sequence_in;
    logic        in_valid;
    logic        cfg_load;
    logic [7:0]  pattern;
    logic [3:0]  pattern_len;
    logic        overlap_en;
    logic        count_clear;

    logic        detector_out;
    logic [15:0] match_count;
    logic        cfg_err;
    logic        sat_detector_out;
    logic [1:0]  sat_match_count;
    logic        sat_cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sequence_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) u_dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .cfg_load     (cfg_load),
        .pattern      (pattern),
        .pattern_len  (pattern_len),
        .overlap_en   (overlap_en),
        .count_clear  (count_clear),
        .detector_out (detector_out),
        .match_count  (match_count),
        .cfg_err      (cfg_err)
    );

    sequence_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_dut_sat (
        .clock        (clock),
        .reset_n      (reset_n),
        .sequence_in  (sequence_in),
        .in_valid     (in_valid),
        .cfg_load     (cfg_load),
        .pattern      (pattern),
        .pattern_len  (pattern_len),
        .overlap_en   (overlap_en),
        .count_clear  (count_clear),
        .detector_out (sat_detector_out),
        .match_count  (sat_match_count),
        .cfg_err      (sat_cfg_err)
    );

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of data with no config/clear, sample #1 after the edge.
    task automatic apply_stimulus(input logic bit_in, input logic valid,
                                  input logic clr = 1'b0);
        sequence_in = bit_in;
        in_valid    = valid;
        cfg_load    = 1'b0;
        count_clear = clr;
        @(posedge clock);
        #1;
        in_valid    = 1'b0;
        count_clear = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len,
                            input logic ovl, input logic bit_in = 1'b0,
                            input logic valid = 1'b0);
        pattern     = pat;
        pattern_len = len;
        overlap_en  = ovl;
        sequence_in = bit_in;
        in_valid    = valid;
        cfg_load    = 1'b1;
        count_clear = 1'b0;
        @(posedge clock);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic clear_count();
        apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("count_clear", 32'(match_count), 32'd0);
    endtask

    // Feed n valid bits (MSB of the used range first) and check the pulse
    // expected after each edge.
    task automatic feed_and_check(input string tag, input int n,
                                  input logic [15:0] bits,
                                  input logic [15:0] exp_det);
        for (int i = n - 1; i >= 0; i--) begin
            apply_stimulus(bits[i], 1'b1);
            check_output($sformatf("%s_det[%0d]", tag, n - i),
                         32'(detector_out), 32'(exp_det[i]));
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        sequence_in = 1'b0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        pattern     = '0;
        pattern_len = '0;
        overlap_en  = 1'b0;
        count_clear = 1'b0;

        // Reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        check_output("rst_det", 32'(detector_out), 32'd0);
        check_output("rst_count", 32'(match_count), 32'd0);
        check_output("rst_cfg_err", 32'(cfg_err), 32'd0);
        check_output("rst_sat_count", 32'(sat_match_count), 32'd0);
        reset_n = 1'b1;

        $display("[TB] overlapping 1011");
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        check_output("ovl_cfg_err", 32'(cfg_err), 32'd0);
        feed_and_check("ovl", 7, 16'b1011011, 16'b0001001);
        check_output("ovl_count", 32'(match_count), 32'd2);
        apply_stimulus(1'b1, 1'b0);
        check_output("ovl_idle_det", 32'(detector_out), 32'd0);

        $display("[TB] non-overlapping 1011");
        load_cfg(8'b0000_1011, 4'd4, 1'b0);
        check_output("novl_count_kept", 32'(match_count), 32'd2);
        clear_count();
        feed_and_check("novl_a", 7, 16'b1011011, 16'b0001000);
        check_output("novl_count_a", 32'(match_count), 32'd1);
        feed_and_check("novl_b", 4, 16'b1011, 16'b0001);
        check_output("novl_count_b", 32'(match_count), 32'd2);

        $display("[TB] gaps between valid bits");
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        clear_count();
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] gbits;
            gbits = 4'b1011;
            apply_stimulus(gbits[i], 1'b1);
            check_output($sformatf("gap_det_valid[%0d]", 4 - i),
                         32'(detector_out), (i == 0) ? 32'd1 : 32'd0);
            for (int g = 0; g < 3; g++) begin
                apply_stimulus(~gbits[i], 1'b0);
                check_output($sformatf("gap_det_idle[%0d.%0d]", 4 - i, g),
                             32'(detector_out), 32'd0);
            end
        end
        check_output("gap_count", 32'(match_count), 32'd1);

        $display("[TB] zero length");
        load_cfg(8'h00, 4'd0, 1'b1);
        check_output("len0_cfg_err", 32'(cfg_err), 32'd1);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 1'b1);
            check_output($sformatf("len0_det[%0d]", i), 32'(detector_out), 32'd0);
        end
        check_output("len0_count", 32'(match_count), 32'd1);

        $display("[TB] oversize length clamps to 8");
        load_cfg(8'hA5, 4'd12, 1'b1);
        check_output("len12_cfg_err", 32'(cfg_err), 32'd1);
        feed_and_check("len12", 8, 16'b10100101, 16'b00000001);
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        check_output("good_cfg_err", 32'(cfg_err), 32'd0);

        $display("[TB] reset mid-stream");
        feed_and_check("mid_pre", 3, 16'b101, 16'b000);
        reset_n = 1'b0;
        apply_stimulus(1'b1, 1'b1);
        reset_n = 1'b1;
        check_output("mid_rst_det", 32'(detector_out), 32'd0);
        check_output("mid_rst_count", 32'(match_count), 32'd0);
        check_output("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
        // Config was cleared by reset: a full pattern must not match now.
        feed_and_check("mid_nocfg", 4, 16'b1011, 16'b0000);
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        feed_and_check("mid_one", 1, 16'b1, 16'b0);
        check_output("mid_one_count", 32'(match_count), 32'd0);
        feed_and_check("mid_full", 4, 16'b1011, 16'b0001);
        check_output("mid_full_count", 32'(match_count), 32'd1);

        $display("[TB] saturation and clear");
        reset_n = 1'b0;
        apply_stimulus(1'b0, 1'b0);
        reset_n = 1'b1;
        load_cfg(8'h01, 4'd1, 1'b1);
        check_output("sat_cfg_err", 32'(sat_cfg_err), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(1'b1, 1'b1);
            check_output($sformatf("sat_det[%0d]", i), 32'(sat_detector_out), 32'd1);
            check_output($sformatf("sat_count[%0d]", i), 32'(sat_match_count),
                         (i >= 3) ? 32'd3 : 32'(i));
        end
        check_output("sat_main_count", 32'(match_count), 32'd5);
        apply_stimulus(1'b1, 1'b1, 1'b1);
        check_output("clr_match_det", 32'(sat_detector_out), 32'd1);
        check_output("clr_match_sat", 32'(sat_match_count), 32'd0);
        check_output("clr_match_main", 32'(match_count), 32'd0);
        apply_stimulus(1'b1, 1'b1);
        check_output("after_clr_sat", 32'(sat_match_count), 32'd1);

        $display("[TB] cfg_load beats in_valid");
        load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1);
        check_output("ld_det", 32'(detector_out), 32'd0);
        feed_and_check("ld_a", 3, 16'b011, 16'b000);
        feed_and_check("ld_b", 3, 16'b011, 16'b001);
        check_output("ld_count", 32'(match_count), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
